// File: rtl/forward_ctrl.sv
// forward_ctrl: operand-forwarding and load-use stall control for a 5-stage pipeline.
// It shadows the destination info of the EX, MEM and WB instructions and produces
// EX-aligned, registered operand-mux selects plus a combinational stall.
// Optional build macro FWD_STALL_CNT_EN adds a saturating 32-bit stall cycle counter
// (output stall_cnt).
module forward_ctrl (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        id_valid,
   input  logic [4:0]  id_rs1,
   input  logic [4:0]  id_rs2,
   input  logic        id_use_rs1,
   input  logic        id_use_rs2,
   input  logic [4:0]  id_rd,
   input  logic        id_we,
   input  logic        id_load,
   input  logic        flush,
   output logic [1:0]  fwd_a_sel,
   output logic [1:0]  fwd_b_sel,
   output logic        stall
`ifdef FWD_STALL_CNT_EN
   ,
   output logic [31:0] stall_cnt
`endif
);

   localparam int unsigned REG_W = 5;
   localparam int unsigned SEL_W = 2;

   localparam logic [0:0] ST_RUN  = 1'b0;
   localparam logic [0:0] ST_HOLD = 1'b1;

   localparam logic [SEL_W-1:0] SEL_RF     = 2'b00;
   localparam logic [SEL_W-1:0] SEL_EX_ALU = 2'b01;
   localparam logic [SEL_W-1:0] SEL_WB_ALU = 2'b10;
   localparam logic [SEL_W-1:0] SEL_WB_LD  = 2'b11;

   // Tracker entries {valid, rd, we, load} for EX, MEM and WB
   logic             ex_valid_q,  ex_valid_d;
   logic [REG_W-1:0] ex_rd_q,     ex_rd_d;
   logic             ex_we_q,     ex_we_d;
   logic             ex_load_q,   ex_load_d;
   logic             mem_valid_q, mem_valid_d;
   logic [REG_W-1:0] mem_rd_q,    mem_rd_d;
   logic             mem_we_q,    mem_we_d;
   logic             mem_load_q,  mem_load_d;
   logic             wb_valid_q,  wb_valid_d;
   logic [REG_W-1:0] wb_rd_q,     wb_rd_d;
   logic             wb_we_q,     wb_we_d;
   logic             wb_load_q,   wb_load_d;

   logic [0:0]       state_q, state_d;
   logic [SEL_W-1:0] fwd_a_sel_q, fwd_a_sel_d;
   logic [SEL_W-1:0] fwd_b_sel_q, fwd_b_sel_d;

   logic ex_hit_a, ex_hit_b, mem_hit_a, mem_hit_b;
   logic id_advance;

   // An entry forwards to a source only if it really writes that nonzero register
   function automatic logic entry_match(input logic             valid,
                                        input logic             we,
                                        input logic [REG_W-1:0] rd,
                                        input logic [REG_W-1:0] src,
                                        input logic             use_src);
      return valid & we & (rd != '0) & (rd == src) & use_src;
   endfunction

   // Younger producer (EX) has priority over MEM
   function automatic logic [SEL_W-1:0] pick_sel(input logic ex_hit,
                                                 input logic mem_hit,
                                                 input logic mem_load);
      logic [SEL_W-1:0] sel;
      sel = SEL_RF;
      if (ex_hit)
         sel = SEL_EX_ALU;
      else if (mem_hit && mem_load)
         sel = SEL_WB_LD;
      else if (mem_hit)
         sel = SEL_WB_ALU;
      return sel;
   endfunction

   // Hazard detection against the EX and MEM entries
   always_comb begin
      ex_hit_a  = entry_match(ex_valid_q,  ex_we_q,  ex_rd_q,  id_rs1, id_use_rs1);
      ex_hit_b  = entry_match(ex_valid_q,  ex_we_q,  ex_rd_q,  id_rs2, id_use_rs2);
      mem_hit_a = entry_match(mem_valid_q, mem_we_q, mem_rd_q, id_rs1, id_use_rs1);
      mem_hit_b = entry_match(mem_valid_q, mem_we_q, mem_rd_q, id_rs2, id_use_rs2);
   end

   // Load-use stall: a flush squashes the consumer, so it never stalls
   assign stall = id_valid & ex_load_q & (ex_hit_a | ex_hit_b) & ~flush
                  & (state_q == ST_RUN);

   assign id_advance = id_valid & ~stall & ~flush;

   // Next state: FSM, tracker shift, registered selects
   always_comb begin
      state_d     = state_q;
      fwd_a_sel_d = SEL_RF;
      fwd_b_sel_d = SEL_RF;

      unique case (state_q)
         ST_RUN:  if (stall) state_d = ST_HOLD;
         ST_HOLD: state_d = ST_RUN;
         default: state_d = ST_RUN;
      endcase

      wb_valid_d  = mem_valid_q;
      wb_rd_d     = mem_rd_q;
      wb_we_d     = mem_we_q;
      wb_load_d   = mem_load_q;

      mem_valid_d = ex_valid_q & ~flush;
      mem_rd_d    = ex_rd_q;
      mem_we_d    = ex_we_q;
      mem_load_d  = ex_load_q;

      ex_valid_d  = id_advance;
      ex_rd_d     = id_rd;
      ex_we_d     = id_we;
      ex_load_d   = id_load;

      if (id_advance) begin
         fwd_a_sel_d = pick_sel(ex_hit_a, mem_hit_a, mem_load_q);
         fwd_b_sel_d = pick_sel(ex_hit_b, mem_hit_b, mem_load_q);
      end
   end

   // State and tracker registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_RUN;
         fwd_a_sel_q <= SEL_RF;
         fwd_b_sel_q <= SEL_RF;
         ex_valid_q  <= 1'b0;
         ex_rd_q     <= '0;
         ex_we_q     <= 1'b0;
         ex_load_q   <= 1'b0;
         mem_valid_q <= 1'b0;
         mem_rd_q    <= '0;
         mem_we_q    <= 1'b0;
         mem_load_q  <= 1'b0;
         wb_valid_q  <= 1'b0;
         wb_rd_q     <= '0;
         wb_we_q     <= 1'b0;
         wb_load_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         fwd_a_sel_q <= fwd_a_sel_d;
         fwd_b_sel_q <= fwd_b_sel_d;
         ex_valid_q  <= ex_valid_d;
         ex_rd_q     <= ex_rd_d;
         ex_we_q     <= ex_we_d;
         ex_load_q   <= ex_load_d;
         mem_valid_q <= mem_valid_d;
         mem_rd_q    <= mem_rd_d;
         mem_we_q    <= mem_we_d;
         mem_load_q  <= mem_load_d;
         wb_valid_q  <= wb_valid_d;
         wb_rd_q     <= wb_rd_d;
         wb_we_q     <= wb_we_d;
         wb_load_q   <= wb_load_d;
      end
   end

   assign fwd_a_sel = fwd_a_sel_q;
   assign fwd_b_sel = fwd_b_sel_q;

   // WB is tracked for completeness only (the register file writes before it reads)
   a_wb_follows_mem: assert property (@(posedge clk) disable iff (!rst_n)
      {wb_valid_q, wb_rd_q, wb_we_q, wb_load_q} ==
      $past({mem_valid_q, mem_rd_q, mem_we_q, mem_load_q}));

`ifdef FWD_STALL_CNT_EN
   localparam int unsigned CNT_W = 32;

   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

   // Saturating count of stall cycles
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (stall && (stall_cnt_q != '1))
         stall_cnt_d = stall_cnt_q + CNT_W'(1);
   end

   // Counter register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         stall_cnt_q <= '0;
      else
         stall_cnt_q <= stall_cnt_d;
   end

   assign stall_cnt = stall_cnt_q;
`endif

endmodule
